// File: rtl/register_pipeline.sv
// register_pipeline
//   Fixed-latency, stallable delay line: SIZE cascaded WIDTH-bit registers
//   that share one clock enable. A word taken in on datain at an enabled
//   edge appears on dataout after SIZE enabled edges. Disabled edges
//   freeze every stage together, so word order and spacing are preserved.
//
// Ports
//   clk      rising-edge clock for all state
//   reset    synchronous, active-high; clears every stage, overrides enable
//   enable   shift enable; low holds the whole pipeline
//   datain   WIDTH-bit word entering stage 0
//   dataout  WIDTH-bit word from the last stage (registered, no comb path)
module register_pipeline #(
    parameter int WIDTH = 16,
    parameter int SIZE  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] datain,
    output logic [WIDTH-1:0] dataout
);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("register_pipeline: WIDTH must be >= 1");
        end
        if (SIZE < 1) begin : g_bad_size
            $error("register_pipeline: SIZE must be >= 1");
        end
    endgenerate

    logic [WIDTH-1:0] stage [SIZE];

    // Reset is applied to the data stages too: in-flight words must be
    // discarded so that nothing stale ever reaches dataout after a reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SIZE; i++) begin
                stage[i] <= '0;
            end
        end else if (enable) begin
            stage[0] <= datain;
            for (int i = 1; i < SIZE; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dataout = stage[SIZE-1];

endmodule

// File: tb/tb_register_pipeline.sv
module tb_register_pipeline;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [WIDTH-1:0] datain;
    logic [WIDTH-1:0] dataout8;
    logic [WIDTH-1:0] dataout1;

    int checks = 0;
    int errors = 0;

    // Reference: every word accepted on an enabled edge since the last
    // reset, in arrival order. A SIZE-deep line outputs the word accepted
    // SIZE enabled edges ago, or zero if fewer than SIZE were accepted.
    logic [WIDTH-1:0] hist [$];

    always #5 clk = ~clk;

    register_pipeline #(.WIDTH(WIDTH), .SIZE(8)) dut8 (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .datain  (datain),
        .dataout (dataout8)
    );

    register_pipeline #(.WIDTH(WIDTH), .SIZE(1)) dut1 (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .datain  (datain),
        .dataout (dataout1)
    );

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] expected(input int sz);
        int n;
        n = hist.size();
        if (n >= sz) return hist[n-sz];
        return '0;
    endfunction

    // One clock: drive on the falling edge, let the rising edge happen,
    // update the reference, then sample both DUTs just after the edge.
    task automatic step(input string tag, input logic r, input logic e,
                        input logic [WIDTH-1:0] d);
        @(negedge clk);
        reset  = r;
        enable = e;
        datain = d;
        @(posedge clk);
        if (r) hist.delete();
        else if (e) hist.push_back(d);
        #1;
        check({tag, "_s8"}, dataout8, expected(8));
        check({tag, "_s1"}, dataout1, expected(1));
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        datain = '0;

        // Reset state
        step("rst_init", 1'b1, 1'b0, 16'h0000);
        step("rst_init", 1'b1, 1'b0, 16'h0000);

        // Preload nonzero data, then reset held for 2 edges with enable high
        for (int i = 0; i < 10; i++) step("preload", 1'b0, 1'b1, 16'hC3C3 + i[15:0]);
        step("rst_hold", 1'b1, 1'b1, 16'hFFFF);
        check("rst_hold_zero", dataout8, 16'h0000);
        step("rst_hold", 1'b1, 1'b1, 16'hFFFF);
        check("rst_hold_zero", dataout8, 16'h0000);

        // Latency: 1,2,3,... one per enabled edge
        for (int i = 1; i <= 20; i++) begin
            step("latency", 1'b0, 1'b1, i[15:0]);
            if (i == 7) check("latency_edge7", dataout8, 16'd0);
            if (i == 8) check("latency_edge8", dataout8, 16'd1);
            if (i == 9) check("latency_edge9", dataout8, 16'd2);
        end

        // Stall mid-stream with changing datain
        for (int i = 0; i < 3; i++) begin
            step("stall", 1'b0, 1'b0, 16'hDEAD + i[15:0]);
            check("stall_frozen", dataout8, 16'd13);
        end
        for (int i = 21; i <= 32; i++) step("resume", 1'b0, 1'b1, i[15:0]);
        check("resume_order", dataout8, 16'd25);

        // Reset mid-stream with the pipeline full of A5A5
        for (int i = 0; i < 8; i++) step("fill_a5", 1'b0, 1'b1, 16'hA5A5);
        check("full_a5", dataout8, 16'hA5A5);
        step("rst_mid", 1'b1, 1'b0, 16'h0000);
        for (int i = 1; i <= 10; i++) begin
            step("post_rst", 1'b0, 1'b1, 16'h1234);
            if (i < 8) check("post_rst_zero", dataout8, 16'h0000);
            else check("post_rst_word", dataout8, 16'h1234);
        end

        // Extremes, bit-exact
        for (int i = 0; i < 18; i++) begin
            logic [WIDTH-1:0] v;
            case (i % 3)
                0: v = 16'h0000;
                1: v = 16'hFFFF;
                default: v = 16'h8001;
            endcase
            step("extreme", 1'b0, 1'b1, v);
        end

        // Random scoreboard: random data, random enable, rare resets
        for (int i = 0; i < 1000; i++) begin
            logic r;
            r = ($urandom_range(0, 99) == 0);
            step("random", r, 1'(($urandom & 3) != 0), 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
